// File: rtl/pipe_pkg.sv
// Shared types for the elastic pipeline stages: occupancy state and the
// packed payload bundles carried across each pipeline boundary.
package pipe_pkg;

  localparam int PIPE_CNT_W = 2;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } pipe_state_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } if_id_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] rs1_val;
    logic [31:0] rs2_val;
    logic [31:0] imm;
    logic [4:0]  rd;
    logic [3:0]  alu_op;
    logic        mem_rd;
    logic        mem_wr;
    logic        reg_wr;
  } id_ex_t;

  typedef struct packed {
    logic [31:0] alu_res;
    logic [31:0] st_data;
    logic [4:0]  rd;
    logic        mem_rd;
    logic        mem_wr;
    logic        reg_wr;
  } ex_mem_t;

  typedef struct packed {
    logic [31:0] wb_data;
    logic [4:0]  rd;
    logic        reg_wr;
  } mem_wb_t;

endpackage

// File: rtl/pipe_buffer.sv
// Elastic pipeline register: main register drives the output, a skid
// register absorbs one extra payload so in_ready never depends on out_ready.
module pipe_buffer
  import pipe_pkg::*;
#(
  parameter int               WIDTH     = 32,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic                  clk_datapath,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [WIDTH-1:0]      in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [WIDTH-1:0]      out_data,
  input  logic                  flush,
  output logic [PIPE_CNT_W-1:0] count
);

  pipe_state_t      state_q, state_d;
  logic [WIDTH-1:0] main_q, main_d;
  logic [WIDTH-1:0] skid_q, skid_d;
  logic             main_vld, skid_vld;
  logic             accept, pop;

  // Valid bits are decoded from occupancy: main is filled first, skid second.
  assign main_vld  = (state_q != EMPTY);
  assign skid_vld  = (state_q == FULL);

  assign in_ready  = !skid_vld && !flush;
  assign out_valid = main_vld;
  assign out_data  = main_q;
  assign accept    = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  assign count = (state_q == FULL) ? PIPE_CNT_W'(2) :
                 (state_q == ONE)  ? PIPE_CNT_W'(1) : PIPE_CNT_W'(0);

  // Next occupancy and data moves; flush empties the stage but leaves the
  // data registers untouched since their contents are dead once invalid.
  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (flush) begin
      state_d = EMPTY;
    end else begin
      unique case (state_q)
        EMPTY: begin
          if (accept) begin
            state_d = ONE;
            main_d  = in_data;
          end
        end
        ONE: begin
          if (accept && pop) begin
            main_d  = in_data;
          end else if (accept) begin
            state_d = FULL;
            skid_d  = in_data;
          end else if (pop) begin
            state_d = EMPTY;
          end
        end
        FULL: begin
          if (pop) begin
            state_d = ONE;
            main_d  = skid_q;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  // State and data registers; reset clears the stage without a clock edge.
  always_ff @(posedge clk_datapath or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= EMPTY;
      main_q  <= RESET_VAL;
      skid_q  <= RESET_VAL;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
    end
  end

endmodule

// File: tb/tb_pipe_buffer.sv
// Bench for pipe_buffer: three instances (WIDTH 32 / 7 / 96), directed
// scenarios on the 32-bit one, then random valid/ready/flush on all three.
// The reference is a bounded FIFO (capacity 2) per instance.
module tb_pipe_buffer;

  localparam int NW = 3;
  localparam int MW = 96;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic          in_valid  [NW];
  logic          in_ready  [NW];
  logic          out_valid [NW];
  logic          out_ready [NW];
  logic          flush     [NW];
  logic [MW-1:0] in_data   [NW];
  logic [MW-1:0] out_data  [NW];
  logic [1:0]    count     [NW];
  logic [MW-1:0] rst_val   [NW];
  logic [MW-1:0] mask      [NW];

  for (genvar g = 0; g < NW; g++) begin : g_dut
    localparam int W = (g == 0) ? 32 : (g == 1) ? 7 : 96;
    localparam logic [W-1:0] RV = (g == 0) ? W'(32'hDEAD_BEEF) : W'(0);
    logic [W-1:0] od;
    pipe_buffer #(.WIDTH(W), .RESET_VAL(RV)) u_dut (
      .clk_datapath (clk),
      .rst_n        (rst_n),
      .in_valid     (in_valid[g]),
      .in_ready     (in_ready[g]),
      .in_data      (in_data[g][W-1:0]),
      .out_valid    (out_valid[g]),
      .out_ready    (out_ready[g]),
      .out_data     (od),
      .flush        (flush[g]),
      .count        (count[g])
    );
    assign out_data[g] = MW'(od);
    assign rst_val[g]  = MW'(RV);
    assign mask[g]     = MW'({W{1'b1}});
  end

  // Reference model: per-instance FIFO of accepted payloads, capacity 2.
  logic [MW-1:0] q [NW][$];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input int i, input logic [MW-1:0] act,
                     input logic [MW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s[%0d] at %0t: got %h, expected %h", nm, i, $time, act, exp);
    end
  endtask

  task automatic chk_reset();
    for (int i = 0; i < NW; i++) begin
      chk("rst_out_valid", i, MW'(out_valid[i]), MW'(0));
      chk("rst_in_ready", i, MW'(in_ready[i]), MW'(1));
      chk("rst_count", i, MW'(count[i]), MW'(0));
      chk("rst_out_data", i, out_data[i], rst_val[i]);
      q[i].delete();
    end
  endtask

  // Monitor: on each falling edge, compare DUT status with the model, pop and
  // compare data on a transfer, then advance the model to the next edge.
  always begin
    @(negedge clk or negedge rst_n);
    if (clk) begin
      #1;
      chk_reset();
    end else if (!rst_n) begin
      chk_reset();
    end else begin
      for (int i = 0; i < NW; i++) begin
        int n;
        n = q[i].size();
        chk("count", i, MW'(count[i]), MW'(n));
        chk("out_valid", i, MW'(out_valid[i]), MW'(n > 0));
        chk("in_ready", i, MW'(in_ready[i]), MW'(n < 2 && !flush[i]));
        if (out_valid[i] && out_ready[i]) begin
          if (n == 0) begin
            checks++;
            errors++;
            $display("FAIL pop_empty[%0d] at %0t: got data %h, expected none",
                     i, $time, out_data[i]);
          end else begin
            chk("pop_data", i, out_data[i], q[i].pop_front());
          end
        end
        if (flush[i]) q[i].delete();
        else if (in_valid[i] && n < 2) q[i].push_back(in_data[i] & mask[i]);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < NW; i++) begin
      in_valid[i] = 1'b0; out_ready[i] = 1'b0; flush[i] = 1'b0; in_data[i] = '0;
    end
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    step();

    // Streaming 1..8 with downstream always ready
    out_ready[0] = 1'b1; in_valid[0] = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      in_data[0] = MW'(k);
      step();
    end
    in_valid[0] = 1'b0;
    repeat (2) step();

    // Back-pressure: A, B absorbed, C waits until in_ready returns
    out_ready[0] = 1'b0; in_valid[0] = 1'b1;
    in_data[0] = MW'(32'hA); step();
    in_data[0] = MW'(32'hB); step();
    in_data[0] = MW'(32'hC); repeat (2) step();
    out_ready[0] = 1'b1;
    for (int k = 0; k < 10 && !in_ready[0]; k++) step();
    step();
    in_valid[0] = 1'b0;
    repeat (3) step();

    // Flush while FULL with a competing offer
    out_ready[0] = 1'b0; in_valid[0] = 1'b1;
    in_data[0] = MW'(32'h10); step();
    in_data[0] = MW'(32'h20); step();
    in_data[0] = MW'(32'h30); flush[0] = 1'b1; step();
    flush[0] = 1'b0; in_valid[0] = 1'b0; repeat (2) step();

    // Flush with simultaneous pop from ONE
    in_valid[0] = 1'b1; in_data[0] = MW'(32'h55); step();
    in_valid[0] = 1'b0; out_ready[0] = 1'b1; flush[0] = 1'b1; step();
    flush[0] = 1'b0; repeat (2) step();

    // Asynchronous reset between edges while holding two payloads
    out_ready[0] = 1'b0; in_valid[0] = 1'b1;
    in_data[0] = MW'(32'h66); step();
    in_data[0] = MW'(32'h77); step();
    in_valid[0] = 1'b0;
    @(posedge clk);
    #3 rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    in_valid[0] = 1'b1; out_ready[0] = 1'b1; in_data[0] = MW'(32'h88); step();
    in_valid[0] = 1'b0; repeat (3) step();

    // Random traffic on all instances
    for (int c = 0; c < 10000; c++) begin
      for (int i = 0; i < NW; i++) begin
        in_valid[i]  = ($urandom_range(0, 3) != 0);
        out_ready[i] = ($urandom_range(0, 2) != 0);
        flush[i]     = ($urandom_range(0, 31) == 0);
        in_data[i]   = {$urandom(), $urandom(), $urandom()};
      end
      step();
    end
    for (int i = 0; i < NW; i++) begin
      in_valid[i] = 1'b0; out_ready[i] = 1'b1; flush[i] = 1'b0;
    end
    repeat (4) step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
